// File: rtl/instruction_executor.sv
// Executes one GPU draw instruction at a time against the framebuffer write port.
// Holds the draw state (colour, cursor) and pulses o_instr_done to release the upstream buffer.
module instruction_executor #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_instr_valid,
  input  logic [31:0]        i_instruction,
  output logic               o_instr_done,
  output logic               o_busy,
  output logic               o_illegal,
  output logic               o_fb_we,
  output logic [ADDR_W-1:0]  o_fb_addr,
  output logic [COLOR_W-1:0] o_fb_data,
  input  logic               i_fb_ready
);

  localparam int CNT_W = ADDR_W + 1;

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_SET_COLOR = 4'h1;
  localparam logic [3:0] OP_SET_XY    = 4'h2;
  localparam logic [3:0] OP_PIXEL     = 4'h3;
  localparam logic [3:0] OP_HLINE     = 4'h4;
  localparam logic [3:0] OP_CLEAR     = 4'h5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [9:0]         cur_x_q, cur_x_d;
  logic [8:0]         cur_y_q, cur_y_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               illegal_q, illegal_d;

  logic [3:0]         op;
  logic [9:0]         arg_x;
  logic [8:0]         arg_y;
  logic [9:0]         arg_len;
  logic [COLOR_W-1:0] arg_col;
  logic               xy_out_of_range;
  logic [ADDR_W-1:0]  cursor_addr;
  logic [CNT_W-1:0]   hline_room;
  logic [CNT_W-1:0]   len_ext;
  logic [CNT_W-1:0]   hline_count;

  assign op      = instr_q[31:28];
  assign arg_x   = instr_q[27:18];
  assign arg_y   = instr_q[17:9];
  assign arg_len = instr_q[9:0];
  assign arg_col = instr_q[COLOR_W-1:0];

  assign xy_out_of_range = (int'(arg_x) >= H_RES) || (int'(arg_y) >= V_RES);
  assign cursor_addr     = ADDR_W'(cur_y_q) * ADDR_W'(H_RES) + ADDR_W'(cur_x_q);

  // Cursor is always a legal coordinate, so the room left on the line is at least one pixel.
  assign hline_room  = CNT_W'(H_RES) - CNT_W'(cur_x_q);
  assign len_ext     = CNT_W'(arg_len);
  assign hline_count = (len_ext < hline_room) ? len_ext : hline_room;

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    color_d   = color_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    addr_d    = addr_q;
    count_d   = count_q;
    illegal_d = illegal_q;

    case (state_q)
      S_IDLE: begin
        if (i_instr_valid) begin
          instr_d   = i_instruction;
          illegal_d = 1'b0;
          state_d   = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_DONE;
        case (op)
          OP_NOP: ;
          OP_SET_COLOR: color_d = arg_col;
          OP_SET_XY: begin
            if (xy_out_of_range) begin
              illegal_d = 1'b1;
            end else begin
              cur_x_d = arg_x;
              cur_y_d = arg_y;
            end
          end
          OP_PIXEL: begin
            addr_d  = cursor_addr;
            count_d = CNT_W'(1);
            state_d = S_DRAW;
          end
          OP_HLINE: begin
            addr_d  = cursor_addr;
            count_d = hline_count;
            // A zero-length line retires without touching the framebuffer.
            if (arg_len != 10'd0) state_d = S_DRAW;
          end
          OP_CLEAR: begin
            addr_d  = '0;
            count_d = CNT_W'(H_RES * V_RES);
            state_d = S_DRAW;
          end
          default: illegal_d = 1'b1;
        endcase
      end

      S_DRAW: begin
        if (i_fb_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      color_q   <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      color_q   <= color_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Decoded straight from the state register so a reset drops the write strobe at once.
  assign o_fb_we      = (state_q == S_DRAW);
  assign o_instr_done = (state_q == S_DONE);
  assign o_illegal    = (state_q == S_DONE) && illegal_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_fb_addr    = addr_q;
  assign o_fb_data    = color_q;

endmodule

// File: tb/tb_instruction_executor.sv
// Directed bench for instruction_executor: register ops, draws, stalls, illegal ops and reset abort.
// The frame height is reduced so a full CLEAR stays within a short run.
module tb_instruction_executor;

  localparam int H_RES   = 640;
  localparam int V_RES   = 64;
  localparam int ADDR_W  = 19;
  localparam int COLOR_W = 8;

  logic               i_clk = 1'b0;
  logic               i_reset_n = 1'b0;
  logic               i_instr_valid = 1'b0;
  logic [31:0]        i_instruction = '0;
  logic               i_fb_ready = 1'b1;
  logic               o_instr_done;
  logic               o_busy;
  logic               o_illegal;
  logic               o_fb_we;
  logic [ADDR_W-1:0]  o_fb_addr;
  logic [COLOR_W-1:0] o_fb_data;

  instruction_executor #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W),
    .COLOR_W(COLOR_W)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_instr_valid(i_instr_valid),
    .i_instruction(i_instruction),
    .o_instr_done (o_instr_done),
    .o_busy       (o_busy),
    .o_illegal    (o_illegal),
    .o_fb_we      (o_fb_we),
    .o_fb_addr    (o_fb_addr),
    .o_fb_data    (o_fb_data),
    .i_fb_ready   (i_fb_ready)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] op_color(input int c);
    return {4'h1, 20'd0, 8'(c)};
  endfunction

  function automatic logic [31:0] op_setxy(input int x, input int y);
    return {4'h2, 10'(x), 9'(y), 9'd0};
  endfunction

  function automatic logic [31:0] op_hline(input int len);
    return {4'h4, 18'd0, 10'(len)};
  endfunction

  localparam logic [31:0] OP_PIXEL = 32'h3000_0000;
  localparam logic [31:0] OP_CLEAR = 32'h5000_0000;
  localparam logic [31:0] OP_BAD9  = 32'h9000_0000;

  int          r_writes, r_done_cyc, r_seq_bad, r_data_bad, r_hold_bad, r_stalls, r_ill;
  logic [31:0] r_first, r_last;

  // Issue one instruction from a negedge, hold valid until the done pulse, record all writes.
  task automatic run(input string tag, input logic [31:0] w, input logic [7:0] exp_col,
                     input int stall, input int max_cyc);
    int                cyc = 0;
    bit                done = 0;
    int                left = stall;
    bit                holding = 0;
    logic [ADDR_W-1:0] hold_addr = '0;
    logic [7:0]        hold_data = '0;
    r_writes = 0; r_done_cyc = 0; r_seq_bad = 0; r_data_bad = 0;
    r_hold_bad = 0; r_stalls = 0; r_ill = 0; r_first = 0; r_last = 0;
    i_instruction = w;
    i_instr_valid = 1'b1;
    i_fb_ready    = 1'b1;
    while (!done && cyc < max_cyc) begin
      @(negedge i_clk);
      cyc++;
      if (o_fb_we && left > 0) begin
        i_fb_ready = 1'b0;
        left--;
        r_stalls++;
        if (!holding) begin
          holding   = 1;
          hold_addr = o_fb_addr;
          hold_data = o_fb_data;
        end else if (o_fb_addr !== hold_addr || o_fb_data !== hold_data) begin
          r_hold_bad++;
        end
      end else begin
        i_fb_ready = 1'b1;
      end
      if (o_fb_we && i_fb_ready) begin
        if (holding && (o_fb_addr !== hold_addr || o_fb_data !== hold_data)) r_hold_bad++;
        if (r_writes == 0) r_first = 32'(o_fb_addr);
        else if (32'(o_fb_addr) !== r_last + 1) r_seq_bad++;
        r_last = 32'(o_fb_addr);
        if (o_fb_data !== exp_col) r_data_bad++;
        r_writes++;
      end
      if (o_instr_done) begin
        done          = 1;
        r_done_cyc    = cyc;
        r_ill         = int'(o_illegal);
        i_instr_valid = 1'b0;
      end
    end
    i_instr_valid = 1'b0;
    i_fb_ready    = 1'b1;
    if (!done) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
    end else begin
      @(negedge i_clk);
      check({tag, " done single"}, 32'(o_instr_done), 32'd0);
      check({tag, " idle after"}, 32'(o_busy), 32'd0);
    end
    $display("txn %s: instr=0x%08h writes=%0d first=%0d last=%0d done_cyc=%0d illegal=%0d",
             tag, w, r_writes, r_first, r_last, r_done_cyc, r_ill);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge i_clk);
    check("rst done", 32'(o_instr_done), 32'd0);
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst illegal", 32'(o_illegal), 32'd0);
    check("rst we", 32'(o_fb_we), 32'd0);
    check("rst addr", 32'(o_fb_addr), 32'd0);
    check("rst data", 32'(o_fb_data), 32'd0);
    i_reset_n = 1'b1;
    @(negedge i_clk);

    // Load non-zero draw state, then reset in the middle of a CLEAR
    run("color55", op_color(8'h55), 8'h00, 0, 10);
    check("color55 cyc", r_done_cyc, 2);
    run("xy33", op_setxy(3, 3), 8'h00, 0, 10);
    i_instruction = OP_CLEAR;
    i_instr_valid = 1'b1;
    @(negedge i_clk);
    i_instr_valid = 1'b0;
    repeat (10) @(negedge i_clk);
    check("clear drawing we", 32'(o_fb_we), 32'd1);
    #2 i_reset_n = 1'b0;
    #1;
    check("async we drop", 32'(o_fb_we), 32'd0);
    check("async busy drop", 32'(o_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("no done in reset", 32'(o_instr_done), 32'd0);
    end
    i_reset_n = 1'b1;
    run("pix after rst", OP_PIXEL, 8'h00, 0, 10);
    check("rst pix writes", r_writes, 1);
    check("rst pix addr", r_first, 32'd0);
    check("rst pix data", r_data_bad, 0);

    // Colour, cursor and a single pixel
    run("color3c", op_color(8'h3C), 8'h00, 0, 10);
    run("xy10_2", op_setxy(10, 2), 8'h00, 0, 10);
    check("xy10_2 illegal", r_ill, 0);
    run("pix1290", OP_PIXEL, 8'h3C, 0, 10);
    check("pix writes", r_writes, 1);
    check("pix addr", r_first, 32'd1290);
    check("pix data", r_data_bad, 0);
    check("pix latency", r_done_cyc, 3);

    // HLINE clipped at the line end, and zero length
    run("xy636_5", op_setxy(636, 5), 8'h00, 0, 10);
    run("hline10", op_hline(10), 8'h3C, 0, 20);
    check("hline writes", r_writes, 4);
    check("hline first", r_first, 32'd3836);
    check("hline last", r_last, 32'd3839);
    check("hline seq", r_seq_bad, 0);
    check("hline data", r_data_bad, 0);
    run("hline0", op_hline(0), 8'h3C, 0, 10);
    check("hline0 writes", r_writes, 0);
    check("hline0 illegal", r_ill, 0);
    check("hline0 cyc", r_done_cyc, 2);

    // PIXEL stalled by the framebuffer for three cycles
    run("pix stall", OP_PIXEL, 8'h3C, 3, 20);
    check("stall cycles", r_stalls, 3);
    check("stall hold", r_hold_bad, 0);
    check("stall writes", r_writes, 1);
    check("stall addr", r_first, 32'd3836);
    check("stall data", r_data_bad, 0);
    check("stall done cyc", r_done_cyc, 6);

    // Illegal opcode and out-of-range cursor
    run("op9", OP_BAD9, 8'h00, 0, 10);
    check("op9 illegal", r_ill, 1);
    check("op9 cyc", r_done_cyc, 2);
    run("xy640_0", op_setxy(640, 0), 8'h00, 0, 10);
    check("xy640 illegal", r_ill, 1);
    run("xy0_64", op_setxy(0, V_RES), 8'h00, 0, 10);
    check("xy0_64 illegal", r_ill, 1);
    run("pix unchanged", OP_PIXEL, 8'h3C, 0, 10);
    check("cursor kept writes", r_writes, 1);
    check("cursor kept addr", r_first, 32'd3836);
    check("cursor kept illegal", r_ill, 0);

    // Bottom-right corner is still legal
    run("xy639_63", op_setxy(639, V_RES - 1), 8'h00, 0, 10);
    check("corner illegal", r_ill, 0);
    run("hline corner", op_hline(5), 8'h3C, 0, 10);
    check("corner writes", r_writes, 1);
    check("corner addr", r_first, 32'(640 * (V_RES - 1) + 639));

    // Full-frame CLEAR, then an immediate follow-up instruction
    run("colora5", op_color(8'hA5), 8'h00, 0, 10);
    run("clear", OP_CLEAR, 8'hA5, 0, H_RES * V_RES + 10);
    check("clear writes", r_writes, H_RES * V_RES);
    check("clear first", r_first, 32'd0);
    check("clear last", r_last, 32'(H_RES * V_RES - 1));
    check("clear seq", r_seq_bad, 0);
    check("clear data", r_data_bad, 0);
    run("pix after clear", OP_PIXEL, 8'hA5, 0, 10);
    check("post clear latency", r_done_cyc, 3);
    check("post clear addr", r_first, 32'(640 * (V_RES - 1) + 639));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
